data_sram_confreg: RTL and testbench
====================================

// Module: data_sram_confreg
// PURPOSE
//   Responder for the CPU data-SRAM port driven by the MEM stage: decodes each request
//   into a local word RAM or a small memory-mapped config-register block.
//   Returns read data exactly one cycle after the request, the timing the MEM stage expects.
//   Config registers: LED, numeric display, free-running timer, switch input.
// PARAMETERS
//   RAM_AW     16            word-address bits of local RAM (2**RAM_AW x 32b)
//   CONF_BASE  32'hbfaf_0000 config region base; region match on addr[31:16]
// PORTS
//   clk              in   1   clock
//   resetn           in   1   synchronous active-low reset
//   data_sram_en     in   1   request valid this cycle
//   data_sram_we     in   4   byte write enables; 0 = read
//   data_sram_addr   in   32  byte address
//   data_sram_wdata  in   32  write data, byte lane i = wdata[8i+7:8i]
//   data_sram_rdata  out  32  read data, valid the cycle after the request
//   switch_in        in   8   board switches, read-only through SWITCH register
//   led              out  16  LED register value
//   num_data         out  32  numeric display register value
// BEHAVIOUR
//   - Requests are sampled at posedge clk when data_sram_en=1 and resetn=1.
//     No ready/stall; every request is accepted.
//   - Region select: addr[31:16]==CONF_BASE[31:16] -> config block; all other addresses -> RAM.
//     RAM index = addr[RAM_AW+1:2]; higher bits alias; addr[1:0] ignored.
//   - RAM write: lane i written iff we[i]; other lanes keep their value.
//     RAM contents are not reset.
//   - Read latency: rdata is registered, updated at the edge sampling an enabled request.
//     A write request also updates rdata (old word at that address).
//     rdata holds its value while en=0.
//   - Read-during-write to the same word: rdata returns the pre-write (old) data.
//   - Config map (offset = addr[15:0]):
//       0xe000 TIMER   RW  32b
//       0xf020 LED     RW  low 16b; reads {16'b0,led}
//       0xf050 NUM     RW  32b
//       0xf060 SWITCH  RO  {24'b0,switch_in}
//       0xf100 SIMFLAG RO  32'hffff_ffff
//     Unmapped offsets read 0; writes to them are ignored.
//   - Config writes take effect only when we==4'hf.
//     Partial-lane writes to config registers are ignored.
//     Writes to RO registers are ignored.
//   - TIMER: increments by 1 every cycle out of reset; wraps 32'hffff_ffff -> 0.
//     A TIMER write at edge N loads wdata (write wins over increment); counts from edge N+1.
//     A TIMER read returns the value held before the sampling edge.
//   - Config reads return the register value before the sampling edge (write-then-read takes effect next request).
//   - Reset: rdata=0, led=16'hffff, num_data=0, TIMER=0.
//     A request coincident with resetn=0 is dropped: no RAM or config write.
//   - led and num_data drive directly from their registers (no extra latency).
// TESTING
//   - RAM: write 0x1122_3344 @0x100 (we=f), then read @0x100 -> rdata=0x1122_3344 one cycle later.
//     rdata holds with en=0.
//   - Byte lanes: after the above, write 0xAABB_CCDD @0x100 with we=4'b0101 -> read gives 0x11BB_33DD.
//   - Read-during-write: write 0x5 @0x200 over old 0x9 -> rdata that cycle+1 =0x9; next read =0x5.
//   - Config: write LED 0x0000_00A5 (we=f) -> led=16'h00a5.
//     Partial write we=4'b0001 -> led unchanged.
//     Read 0xbfaf_f060 with switch_in=8'h3c -> rdata=0x3c.
//   - TIMER: write 0xffff_fffe at 0xbfaf_e000, idle 3 cycles -> read returns 0x0000_0001 (wrap).
//   - Reset: assert resetn=0 mid-stream with a write pending -> target word unchanged,
//     led=16'hffff, rdata=0, TIMER restarts from 0.

Source files
------------

// File: rtl/data_sram_confreg.sv
// ---------------------------------------------------------------------------
// data_sram_confreg
//   Responder for the CPU data-SRAM port used by the MEM stage. Each request
//   goes either to a local word RAM or to a small block of memory-mapped
//   configuration registers:
//     TIMER   (free-running counter, writable)
//     LED     (low 16 bits)
//     NUM     (numeric display)
//     SWITCH  (board switches, read only)
//     SIMFLAG (constant all-ones, read only)
//   Read data is registered, so it is returned exactly one cycle after the
//   request. This is the timing the MEM stage expects.
//
// Ports
//   clk              clock
//   resetn           synchronous active-low reset
//   data_sram_en     request valid this cycle
//   data_sram_we     byte write enables, 0 = read
//   data_sram_addr   byte address
//   data_sram_wdata  write data, byte lane i = wdata[8i+7:8i]
//   data_sram_rdata  read data, valid the cycle after the request
//   switch_in        board switches
//   led              LED register value
//   num_data         numeric display register value
// ---------------------------------------------------------------------------
module data_sram_confreg #(
  parameter int          RAM_AW    = 16,
  parameter logic [31:0] CONF_BASE = 32'hbfaf_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led,
  output logic [31:0] num_data
);

  localparam logic [15:0] OFF_TIMER   = 16'he000;
  localparam logic [15:0] OFF_LED     = 16'hf020;
  localparam logic [15:0] OFF_NUM     = 16'hf050;
  localparam logic [15:0] OFF_SWITCH  = 16'hf060;
  localparam logic [15:0] OFF_SIMFLAG = 16'hf100;

  localparam int RAM_WORDS = 1 << RAM_AW;

  logic [31:0]       r_ram [RAM_WORDS];
  logic [31:0]       r_rdata;
  logic [31:0]       r_timer;
  logic [15:0]       r_led;
  logic [31:0]       r_num;

  logic              w_isConf;
  logic [15:0]       w_off;
  logic [RAM_AW-1:0] w_ramIdx;
  logic              w_confWr;
  logic [31:0]       w_confRdata;

  // Only the upper half-word selects the config region. Everything else,
  // including the rest of 0xbfaf_xxxx's neighbours, falls through to RAM.
  assign w_isConf = (data_sram_addr[31:16] == CONF_BASE[31:16]);
  assign w_off    = data_sram_addr[15:0];
  assign w_ramIdx = data_sram_addr[RAM_AW+1:2];

  // Config registers only accept full-word writes. Partial-lane stores are
  // dropped so that a stray sb/sh cannot half-update a register.
  assign w_confWr = data_sram_en && w_isConf && (data_sram_we == 4'hf);

  // Config read mux. The values seen here are the pre-edge register values,
  // so a write followed by a read shows up on the next request.
  always_comb begin
    w_confRdata = 32'h0;
    case (w_off)
      OFF_TIMER:   w_confRdata = r_timer;
      OFF_LED:     w_confRdata = {16'h0, r_led};
      OFF_NUM:     w_confRdata = r_num;
      OFF_SWITCH:  w_confRdata = {24'h0, switch_in};
      OFF_SIMFLAG: w_confRdata = 32'hffff_ffff;
      default:     w_confRdata = 32'h0;
    endcase
  end

  // RAM write port. The contents are deliberately not reset. A request that
  // arrives while reset is asserted must not disturb memory.
  always_ff @(posedge clk) begin
    if (resetn && data_sram_en && !w_isConf) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) begin
          r_ram[w_ramIdx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read data. Every enabled request updates it, including
  // writes. Because the RAM update is non-blocking, a write returns the old
  // word. While en=0 the last value is held.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rdata <= 32'h0;
    end else if (data_sram_en) begin
      r_rdata <= w_isConf ? w_confRdata : r_ram[w_ramIdx];
    end
  end

  // Free-running timer. A software write takes priority over the increment,
  // and counting resumes from the loaded value on the following edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_timer <= 32'h0;
    end else if (w_confWr && (w_off == OFF_TIMER)) begin
      r_timer <= data_sram_wdata;
    end else begin
      r_timer <= r_timer + 32'h1;
    end
  end

  // LED and numeric display registers. LEDs come out of reset all on.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_led <= 16'hffff;
      r_num <= 32'h0;
    end else if (w_confWr) begin
      if (w_off == OFF_LED) r_led <= data_sram_wdata[15:0];
      if (w_off == OFF_NUM) r_num <= data_sram_wdata;
    end
  end

  assign data_sram_rdata = r_rdata;
  assign led             = r_led;
  assign num_data        = r_num;

endmodule

// File: tb/tb_data_sram_confreg.sv
// ---------------------------------------------------------------------------
// tb_data_sram_confreg
//   Directed testbench for data_sram_confreg. It checks RAM byte-lane writes,
//   one-cycle read latency, read-during-write, address aliasing, the config
//   register map, timer wrap, and a reset that coincides with a request.
// ---------------------------------------------------------------------------
module tb_data_sram_confreg;

  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch_in;
  logic [15:0] led;
  logic [31:0] num_data;

  int checkCount;
  int errorCount;

  data_sram_confreg dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch_in       (switch_in),
    .led             (led),
    .num_data        (num_data)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Present one request, let it be sampled on the next edge, then drop en.
  // Inputs change 1 unit after the edge, so the DUT never sees them
  // changing at the edge itself.
  task automatic applyStimulus(input logic [3:0] we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    data_sram_en    = 1'b1;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(posedge clk);
    #1;
    data_sram_en = 1'b0;
    data_sram_we = 4'h0;
  endtask

  // Advance n clock edges with no request. The address and data buses are
  // scrambled meanwhile, which must have no effect while en=0.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      data_sram_addr  = 32'h0000_0200 + 32'(i * 4);
      data_sram_wdata = 32'hdead_0000 + 32'(i);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checkCount      = 0;
    errorCount      = 0;
    resetn          = 1'b0;
    data_sram_en    = 1'b0;
    data_sram_we    = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    switch_in       = 8'h3c;

    // Initial reset
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset rdata", data_sram_rdata, 32'h0);
    checkOutput("reset led",   {16'h0, led},    32'h0000_ffff);
    checkOutput("reset num",   num_data,        32'h0);
    resetn = 1'b1;

    // RAM full-word write, then read back one cycle later
    applyStimulus(4'hf, 32'h0000_0100, 32'h1122_3344);
    applyStimulus(4'h0, 32'h0000_0100, 32'h0);
    checkOutput("ram read",  data_sram_rdata, 32'h1122_3344);
    idleCycles(2);
    checkOutput("ram hold",  data_sram_rdata, 32'h1122_3344);

    // Byte lanes 0 and 2 only. The write itself returns the old word.
    applyStimulus(4'b0101, 32'h0000_0100, 32'haabb_ccdd);
    checkOutput("lane wr old", data_sram_rdata, 32'h1122_3344);
    applyStimulus(4'h0, 32'h0000_0100, 32'h0);
    checkOutput("lane read",   data_sram_rdata, 32'h11bb_33dd);

    // Address aliasing above the RAM index, and ignored addr[1:0]
    applyStimulus(4'h0, 32'h0004_0100, 32'h0);
    checkOutput("alias hi",  data_sram_rdata, 32'h11bb_33dd);
    applyStimulus(4'h0, 32'h0000_0103, 32'h0);
    checkOutput("alias lo",  data_sram_rdata, 32'h11bb_33dd);

    // Read-during-write returns the pre-write data
    applyStimulus(4'hf, 32'h0000_0200, 32'h0000_0009);
    applyStimulus(4'hf, 32'h0000_0200, 32'h0000_0005);
    checkOutput("rdw old",   data_sram_rdata, 32'h0000_0009);
    applyStimulus(4'h0, 32'h0000_0200, 32'h0);
    checkOutput("rdw new",   data_sram_rdata, 32'h0000_0005);

    // LED write. rdata returns the old LED value.
    applyStimulus(4'hf, 32'hbfaf_f020, 32'h0000_00a5);
    checkOutput("led wr",     {16'h0, led},    32'h0000_00a5);
    checkOutput("led wr old", data_sram_rdata, 32'h0000_ffff);
    applyStimulus(4'b0001, 32'hbfaf_f020, 32'h0000_005a);
    checkOutput("led partial", {16'h0, led},   32'h0000_00a5);
    applyStimulus(4'h0, 32'hbfaf_f020, 32'h0);
    checkOutput("led read",   data_sram_rdata, 32'h0000_00a5);

    // An address just outside the config region goes to RAM, not to LED
    applyStimulus(4'hf, 32'hbfae_f020, 32'h0000_0001);
    checkOutput("near conf led", {16'h0, led}, 32'h0000_00a5);
    applyStimulus(4'h0, 32'hbfae_f020, 32'h0);
    checkOutput("near conf ram", data_sram_rdata, 32'h0000_0001);

    // NUM register
    applyStimulus(4'hf, 32'hbfaf_f050, 32'h1234_5678);
    checkOutput("num out",   num_data,        32'h1234_5678);
    applyStimulus(4'h0, 32'hbfaf_f050, 32'h0);
    checkOutput("num read",  data_sram_rdata, 32'h1234_5678);

    // Read-only registers and an unmapped offset
    applyStimulus(4'h0, 32'hbfaf_f060, 32'h0);
    checkOutput("switch",    data_sram_rdata, 32'h0000_003c);
    applyStimulus(4'hf, 32'hbfaf_f060, 32'hffff_ffff);
    switch_in = 8'hc3;
    applyStimulus(4'h0, 32'hbfaf_f060, 32'h0);
    checkOutput("switch ro", data_sram_rdata, 32'h0000_00c3);
    applyStimulus(4'h0, 32'hbfaf_f100, 32'h0);
    checkOutput("simflag",   data_sram_rdata, 32'hffff_ffff);
    applyStimulus(4'hf, 32'hbfaf_f000, 32'h7777_7777);
    applyStimulus(4'h0, 32'hbfaf_f000, 32'h0);
    checkOutput("unmapped",  data_sram_rdata, 32'h0);

    // Timer: load 0xffff_fffe, three idle edges, then read shows the wrap
    applyStimulus(4'hf, 32'hbfaf_e000, 32'hffff_fffe);
    idleCycles(3);
    applyStimulus(4'h0, 32'hbfaf_e000, 32'h0);
    checkOutput("timer wrap", data_sram_rdata, 32'h0000_0001);

    // Reset that coincides with a pending RAM write
    applyStimulus(4'hf, 32'h0000_0300, 32'h0000_0077);
    resetn = 1'b0;
    applyStimulus(4'hf, 32'h0000_0300, 32'hdead_beef);
    checkOutput("rst rdata", data_sram_rdata, 32'h0);
    checkOutput("rst led",   {16'h0, led},    32'h0000_ffff);
    checkOutput("rst num",   num_data,        32'h0);
    resetn = 1'b1;
    applyStimulus(4'h0, 32'hbfaf_e000, 32'h0);
    checkOutput("rst timer0", data_sram_rdata, 32'h0);
    applyStimulus(4'h0, 32'hbfaf_e000, 32'h0);
    checkOutput("rst timer1", data_sram_rdata, 32'h0000_0001);
    applyStimulus(4'h0, 32'h0000_0300, 32'h0);
    checkOutput("rst no wr",  data_sram_rdata, 32'h0000_0077);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
